rom_rd_arbiter: RTL
===================

# rom_rd_arbiter

Round-robin arbiter that shares one single-port, 1-cycle-latency coefficient ROM read port among `N_REQ` requesters in the pointwise DoA datapath. Each requester presents an address with valid/ready; the arbiter grants one per cycle, drives the ROM `ren`/`radd`, and returns the ROM word tagged to the winning requester. An optional lock lets one requester hold the port for a burst, bounded by `MAX_LOCK` grants.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `N_ADDR`, 256, ROM depth; `AW = $clog2(N_ADDR)`
- `DATA_WIDTH`, 16, ROM word width
- `MAX_LOCK`, 16, maximum consecutive grants a locked owner may take (≥1)

Ports:
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in N_REQ: per-requester read request
- `req_lock` in N_REQ: request to keep the port after this grant
- `req_addr` in N_REQ*AW: packed addresses, requester i at bits [i*AW +: AW]
- `req_ready` out N_REQ: one-hot grant, combinational, at most one bit set
- `rsp_valid` out N_REQ: one-hot, marks `rsp_data` for that requester
- `rsp_data` out DATA_WIDTH: ROM word
- `rom_ren` out 1: ROM read enable
- `rom_radd` out AW: ROM address
- `rom_wout` in DATA_WIDTH: ROM registered output (valid 1 cycle after `rom_ren`)

## Operation
- Request i is transferred when `req_valid[i] && req_ready[i]`. Requester holds `req_addr`/`req_valid` until granted.
- `rom_ren` = OR of `req_ready`; `rom_radd` = address of the granted requester, 0 when no grant.
- States: UNLOCKED, LOCKED(owner).
- UNLOCKED: winner = first asserted `req_valid` scanning from `ptr+1` upward modulo N_REQ; `ptr` ← winner on grant; `ptr` unchanged with no grant. If winner's `req_lock`=1 → LOCKED(owner=winner), `lock_cnt` ← 1.
- LOCKED: only owner eligible; others see `req_ready`=0. Owner grant with `req_lock`=1 and `lock_cnt` < MAX_LOCK → stay, `lock_cnt`++. Owner grant with `req_lock`=0, or `lock_cnt` = MAX_LOCK at grant → UNLOCKED after this grant, `ptr` ← owner. Owner `req_valid`=0 and `req_lock`=0 → UNLOCKED, no grant that cycle; owner `req_valid`=0 and `req_lock`=1 → stay, idle cycle, count unchanged.
- Tag pipeline: registered one-hot `tag` ← `req_ready`; `rsp_valid` = `tag`, `rsp_data` = `rom_wout` (ROM-latency aligned).
- Simultaneous requests with ptr wrap: ptr=N_REQ-1 scans from 0.
- MAX_LOCK=1: lock never holds beyond one grant (behaves as plain round robin).

## Timing
- Reset values: `ptr`=N_REQ-1 (requester 0 wins first), state UNLOCKED, `lock_cnt`=0, `tag`=0 ⇒ `rsp_valid`=0; `rsp_data` follows `rom_wout` (don't-care while `rsp_valid`=0).
- `req_ready`, `rom_ren`, `rom_radd` combinational from `req_valid`, `req_lock`, state; forced 0 while `rst`=1.
- Grant-to-response latency 1 cycle (2 with output register). Throughput one read per cycle, back-to-back across requesters.
- Reset mid-operation: in-flight tag cleared; no `rsp_valid` for a read granted in the cycle before or during reset.

## Configuration
- `ROM_RD_ARB_OUTREG_EN` defined: `rsp_valid`/`rsp_data` registered once more; latency 2; reset clears `rsp_valid` and `rsp_data` to 0.
- Not defined: `rsp_valid` from `tag` and `rsp_data` = `rom_wout` directly; latency 1.

## Structure
- Shared package `rom_rd_arb_pkg`: state enum (`ST_UNLOCKED`, `ST_LOCKED`), `AW` helper, lock-count width function `$clog2(MAX_LOCK+1)`.
- One sub-module: `rr_pick` — combinational round-robin picker (request vector, pointer → one-hot grant, index). Top holds FSM, counters, tag pipeline.

## Test plan
- Reset, then `req_valid`=4'b1111, no lock → grants 0,1,2,3,0 on consecutive cycles; `rsp_valid` one-hot follows 1 cycle later with `rsp_data`=ROM[addr_i].
- Only requester 2 valid, addresses 0x10,0x11,0x12 → grants every cycle, `rsp_data`=ROM[0x10..0x12] on cycles 1..3 after first grant.
- Requester 1 locks, MAX_LOCK=4, all others valid → four grants to 1, then 2,3,0 round robin, `ptr`=1 after release.
- Owner in LOCKED drops `req_valid` with `req_lock`=1 for 2 cycles → no grants, others blocked; drops `req_lock` → next cycle requester `owner+1` granted.
- Assert `rst` one cycle after a grant → no `rsp_valid` afterwards; first post-reset grant goes to requester 0.
- With `ROM_RD_ARB_OUTREG_EN`: repeat first scenario → identical data/order, `rsp_valid` delayed 2 cycles from grant.

Source files
------------

// File: rtl/rom_rd_arb_pkg.sv
// Shared types and sizing helpers for the coefficient-ROM read-port arbiter.
package rom_rd_arb_pkg;

    // Port ownership: shared round robin, or held by one requester for a burst.
    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } arb_state_t;

    // Observation bundle; widths fit the largest supported configuration
    // (N_REQ <= 8, MAX_LOCK <= 255).
    typedef struct packed {
        arb_state_t  state;
        logic [2:0]  owner;
        logic [2:0]  ptr;
        logic [7:0]  lock_cnt;
    } arb_dbg_t;

    // Address width for a ROM of the given depth (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Counter width able to hold the value MAX_LOCK itself.
    function automatic int lock_cnt_width(input int max_lock);
        return $clog2(max_lock + 1);
    endfunction

endpackage

// File: rtl/rom_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from ptr+1 upward (mod N) and
// returns the first requesting index as one-hot grant plus binary index.
module rom_rd_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Priority scan starting just after the last winner; ptr itself is last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency ROM read port among N_REQ
// requesters, with an optional bounded burst lock per requester.
// Build option: define ROM_RD_ARB_OUTREG_EN to register rsp_valid/rsp_data
// once more (response latency 2 instead of 1).
//
// Handshake: a request i transfers in the cycle where req_valid[i] and
// req_ready[i] are both high; the requester keeps req_valid/req_addr stable
// until then. req_ready is one-hot or zero and depends only on req_valid,
// req_lock and registered state. rsp_valid[i] is a single-cycle strobe that
// marks rsp_data for requester i; there is no back-pressure on responses.
import rom_rd_arb_pkg::*;

module rom_rd_arbiter #(
    parameter int N_REQ      = 4,
    parameter int N_ADDR     = 256,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LOCK   = 16,
    localparam int AW        = addr_width(N_ADDR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_lock,
    input  logic [N_REQ*AW-1:0]   req_addr,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rom_ren,
    output logic [AW-1:0]         rom_radd,
    input  logic [DATA_WIDTH-1:0] rom_wout,
    output arb_dbg_t              dbg
);

    localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LCW = lock_cnt_width(MAX_LOCK);

    arb_state_t       state, state_nxt;
    logic [IW-1:0]    owner, owner_nxt;
    logic [IW-1:0]    ptr, ptr_nxt;
    logic [LCW-1:0]   lock_cnt, lock_cnt_nxt;
    logic [LCW-1:0]   lock_cnt_inc;
    logic [N_REQ-1:0] tag;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;

    rom_rd_arbiter_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Number of grants the owner will have taken including this one.
    assign lock_cnt_inc = lock_cnt + LCW'(1);

    // State register plus the grant tag that lines up with the ROM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_UNLOCKED;
            owner    <= '0;
            ptr      <= IW'(N_REQ - 1);
            lock_cnt <= '0;
            tag      <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            lock_cnt <= lock_cnt_nxt;
            tag      <= grant;
        end
    end

    // Next-state: round robin when unlocked, owner-only burst when locked.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        lock_cnt_nxt = lock_cnt;
        unique case (state)
            ST_UNLOCKED: begin
                if (pick_any) begin
                    ptr_nxt = pick_idx;
                    // A single-grant budget means the lock never holds.
                    if (req_lock[pick_idx] && (MAX_LOCK > 1)) begin
                        state_nxt    = ST_LOCKED;
                        owner_nxt    = pick_idx;
                        lock_cnt_nxt = LCW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (req_valid[owner]) begin
                    if (req_lock[owner] && (lock_cnt_inc < LCW'(MAX_LOCK))) begin
                        lock_cnt_nxt = lock_cnt_inc;
                    end else begin
                        // Last grant of the burst; resume scanning after owner.
                        state_nxt    = ST_UNLOCKED;
                        ptr_nxt      = owner;
                        lock_cnt_nxt = '0;
                    end
                end else if (!req_lock[owner]) begin
                    state_nxt    = ST_UNLOCKED;
                    ptr_nxt      = owner;
                    lock_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_UNLOCKED;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // Grant decode; nothing is granted while reset is held.
    always_comb begin
        grant     = '0;
        grant_idx = pick_idx;
        if (!rst) begin
            unique case (state)
                ST_UNLOCKED: begin
                    grant     = pick_grant;
                    grant_idx = pick_idx;
                end
                ST_LOCKED: begin
                    grant_idx = owner;
                    if (req_valid[owner]) begin
                        grant[owner] = 1'b1;
                    end
                end
                default: begin
                    grant = '0;
                end
            endcase
        end
    end

    assign req_ready = grant;
    assign rom_ren   = |grant;
    assign rom_radd  = (|grant) ? req_addr[grant_idx*AW +: AW] : '0;

`ifdef ROM_RD_ARB_OUTREG_EN
    logic [N_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    // Extra response stage: ROM word and its owner tag registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= tag;
            rsp_data_q  <= rom_wout;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`else
    // A read granted just before reset must not surface during reset.
    assign rsp_valid = tag & {N_REQ{~rst}};
    assign rsp_data  = rom_wout;
`endif

    assign dbg.state    = state;
    assign dbg.owner    = 3'(owner);
    assign dbg.ptr      = 3'(ptr);
    assign dbg.lock_cnt = 8'(lock_cnt);

endmodule
